// File: rtl/morse_pkg.sv
// Shared encodings and timing constants for the Morse sequencer.
// All durations are in Morse time units.
package morse_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        MARK = 3'd1,
        GAP  = 3'd2,
        CGAP = 3'd3,
        WORD = 3'd4
    } state_e;

    localparam logic [2:0] DOT_U   = 3'd1;
    localparam logic [2:0] DASH_U  = 3'd3;
    localparam logic [2:0] EGAP_U  = 3'd1;
    localparam logic [2:0] CGAP_U  = 3'd3;
    localparam logic [2:0] WGAP_U  = 3'd7;
    localparam logic [2:0] MAX_LEN = 3'd5;

    function automatic logic [2:0] clamp_len(input logic [2:0] len);
        return (len > MAX_LEN) ? MAX_LEN : len;
    endfunction

    function automatic logic [2:0] mark_units(input logic is_dash);
        return is_dash ? DASH_U : DOT_U;
    endfunction

endpackage

// File: rtl/morse_sequencer_if.sv
// Character-code handshake between a producer (host or ROM walker) and the sequencer.
interface morse_sequencer_if;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] in_len;
    logic [4:0] in_bits;

    modport master (output in_valid, output in_len, output in_bits, input in_ready);
    modport slave  (input in_valid, input in_len, input in_bits, output in_ready);
endinterface

// File: rtl/morse_sequencer_unit_timer.sv
// Prescaler plus whole-unit counter; expire pulses once `units` units have
// elapsed since the last clear.
module unit_timer #(
    parameter int UNIT_CYCLES = 4,
    parameter int CW          = $clog2(UNIT_CYCLES + 1)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic [2:0] units,
    output logic       expire
);
    logic [CW-1:0] pre_q;
    logic [2:0]    cnt_q;
    logic          tick;
    logic [3:0]    cnt_inc;

    assign tick    = (pre_q == CW'(UNIT_CYCLES - 1));
    assign cnt_inc = {1'b0, cnt_q} + 4'd1;
    assign expire  = tick && (cnt_inc == {1'b0, units});

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            pre_q <= '0;
            cnt_q <= '0;
        end else if (tick) begin
            pre_q <= '0;
            cnt_q <= cnt_q + 3'd1;
        end else begin
            pre_q <= pre_q + CW'(1);
        end
    end
endmodule

// File: rtl/morse_sequencer.sv
// Morse LED sequencer: accepts one character code per handshake and plays it
// out as timed marks and gaps derived from a single programmable time unit.
//
// state | meaning
// IDLE  | waiting for a code, in_ready high
// MARK  | LED on for a dot or dash
// GAP   | 1-unit gap between elements of one character
// CGAP  | 3-unit trailing gap after the last element
// WORD  | 7-unit word space
module morse_sequencer
    import morse_pkg::*;
#(
    parameter int UNIT_CYCLES = 4,
    parameter int CW          = $clog2(UNIT_CYCLES + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    morse_sequencer_if.slave         bus,
    output logic                     led,
    output logic                     busy,
    output logic                     done
);
    state_e     state_q;
    logic       led_q;
    logic       done_q;
    logic [2:0] len_q;
    logic [4:0] bits_q;
    logic [2:0] idx_q;
    logic [2:0] dur_q;
    logic       expire;
    logic       clear;

    assign bus.in_ready = (state_q == IDLE);
    assign busy         = (state_q != IDLE);
    assign led          = led_q;
    assign done         = done_q;

    // Holding the timer cleared through IDLE makes acceptance count as a clear.
    assign clear = (state_q == IDLE) || expire;

    unit_timer #(.UNIT_CYCLES(UNIT_CYCLES), .CW(CW)) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (clear),
        .units  (dur_q),
        .expire (expire)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            led_q   <= 1'b0;
            done_q  <= 1'b0;
            len_q   <= '0;
            bits_q  <= '0;
            idx_q   <= '0;
            dur_q   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        len_q  <= clamp_len(bus.in_len);
                        bits_q <= bus.in_bits;
                        idx_q  <= '0;
                        if (bus.in_len == 3'd0) begin
                            state_q <= WORD;
                            dur_q   <= WGAP_U;
                        end else begin
                            state_q <= MARK;
                            dur_q   <= mark_units(bus.in_bits[0]);
                            led_q   <= 1'b1;
                        end
                    end
                end
                MARK: begin
                    if (expire) begin
                        idx_q <= idx_q + 3'd1;
                        led_q <= 1'b0;
                        if ((idx_q + 3'd1) < len_q) begin
                            state_q <= GAP;
                            dur_q   <= EGAP_U;
                        end else begin
                            state_q <= CGAP;
                            dur_q   <= CGAP_U;
                        end
                    end
                end
                GAP: begin
                    if (expire) begin
                        state_q <= MARK;
                        dur_q   <= mark_units(bits_q[idx_q]);
                        led_q   <= 1'b1;
                    end
                end
                CGAP, WORD: begin
                    if (expire) begin
                        state_q <= IDLE;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    led_q   <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_morse_sequencer.sv
// Self-checking bench for morse_sequencer: directed and random characters
// compared cycle by cycle against a waveform model built from Morse timing rules.
module tb_morse_sequencer;
    localparam int U = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    morse_sequencer_if ifa ();
    morse_sequencer_if ifb ();
    logic led_a, busy_a, done_a;
    logic led_b, busy_b, done_b;

    morse_sequencer #(.UNIT_CYCLES(U)) dut_a (
        .clk(clk), .rst(rst), .bus(ifa.slave), .led(led_a), .busy(busy_a), .done(done_a)
    );
    morse_sequencer #(.UNIT_CYCLES(1)) dut_b (
        .clk(clk), .rst(rst), .bus(ifb.slave), .led(led_b), .busy(busy_b), .done(done_b)
    );

    int n_cmp = 0;
    int n_err = 0;
    bit exp_q[$];

    // Expected led level for each cycle after acceptance; done follows the last entry.
    function automatic void build_exp(input logic [2:0] len, input logic [4:0] bits, input int u);
        int l;
        l = (len > 3'd5) ? 5 : int'(len);
        exp_q.delete();
        if (l == 0) repeat (7 * u) exp_q.push_back(1'b0);
        for (int i = 0; i < l; i++) begin
            repeat ((bits[i] ? 3 : 1) * u) exp_q.push_back(1'b1);
            repeat ((i < l - 1 ? 1 : 3) * u) exp_q.push_back(1'b0);
        end
    endfunction

    task automatic chk(input string tag, input logic got, input logic exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Called at a negedge. When pre_acc is set the code is already on the bus
    // and is taken at the coming edge.
    task automatic play(input logic [2:0] len, input logic [4:0] bits, input bit pre_acc,
                        input bit hold_next, input logic [2:0] nlen, input logic [4:0] nbits);
        if (!pre_acc) begin
            ifa.in_valid = 1'b1;
            ifa.in_len   = len;
            ifa.in_bits  = bits;
            chk("ready_before_accept", ifa.in_ready, 1'b1);
        end
        build_exp(len, bits, U);
        step();
        if (hold_next) begin
            ifa.in_valid = 1'b1;
            ifa.in_len   = nlen;
            ifa.in_bits  = nbits;
        end else begin
            ifa.in_valid = 1'b0;
        end
        for (int k = 0; k < exp_q.size(); k++) begin
            chk($sformatf("led[%0d] len=%0d bits=%b", k, len, bits), led_a, exp_q[k]);
            chk($sformatf("busy[%0d]", k), busy_a, 1'b1);
            chk($sformatf("ready[%0d]", k), ifa.in_ready, 1'b0);
            chk($sformatf("done[%0d]", k), done_a, 1'b0);
            step();
        end
        chk("done_pulse", done_a, 1'b1);
        chk("ready_at_done", ifa.in_ready, 1'b1);
        chk("led_at_done", led_a, 1'b0);
        chk("busy_at_done", busy_a, 1'b0);
    endtask

    logic [2:0] r_len[10];
    logic [4:0] r_bits[10];
    bit         r_chain[10];

    initial begin
        ifa.in_valid = 1'b0; ifa.in_len = '0; ifa.in_bits = '0;
        ifb.in_valid = 1'b0; ifb.in_len = '0; ifb.in_bits = '0;

        // Reset and idle
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_led", led_a, 1'b0);
        chk("rst_busy", busy_a, 1'b0);
        chk("rst_done", done_a, 1'b0);
        chk("rst_ready", ifa.in_ready, 1'b1);
        chk("rst_led_b", led_b, 1'b0);
        rst = 1'b0;
        for (int k = 0; k < 12; k++) begin
            step();
            chk("idle_led", led_a, 1'b0);
            chk("idle_done", done_a, 1'b0);
        end

        // 'S'
        play(3'd3, 5'b00000, 1'b0, 1'b0, 3'd0, 5'd0);
        step();
        // 'O' with 'S' held valid throughout, taken in the done cycle
        play(3'd3, 5'b00111, 1'b0, 1'b1, 3'd3, 5'b00000);
        play(3'd3, 5'b00000, 1'b1, 1'b0, 3'd0, 5'd0);
        step();
        // Word space, then clamped length with junk above element 5
        play(3'd0, 5'b10110, 1'b0, 1'b0, 3'd0, 5'd0);
        step();
        play(3'd7, 5'b10101, 1'b0, 1'b0, 3'd0, 5'd0);
        step();
        play(3'd2, 5'b11101, 1'b0, 1'b0, 3'd0, 5'd0);
        step();

        // Reset during the second unit of a dash
        ifa.in_valid = 1'b1; ifa.in_len = 3'd1; ifa.in_bits = 5'b00001;
        step();
        ifa.in_valid = 1'b0;
        repeat (U + 1) step();
        chk("dash_mid_led", led_a, 1'b1);
        rst = 1'b1;
        step();
        chk("abort_led", led_a, 1'b0);
        chk("abort_ready", ifa.in_ready, 1'b1);
        chk("abort_busy", busy_a, 1'b0);
        chk("abort_done", done_a, 1'b0);
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            step();
            chk("post_abort_done", done_a, 1'b0);
            chk("post_abort_led", led_a, 1'b0);
        end
        play(3'd2, 5'b00001, 1'b0, 1'b0, 3'd0, 5'd0);
        step();

        // Random characters, some chained back-to-back
        for (int i = 0; i < 10; i++) begin
            r_len[i]   = 3'($urandom_range(0, 7));
            r_bits[i]  = 5'($urandom);
            r_chain[i] = bit'($urandom_range(0, 1));
        end
        for (int i = 0; i < 10; i++) begin
            play(r_len[i], r_bits[i], (i > 0) && r_chain[i - 1],
                 (i < 9) && r_chain[i],
                 r_len[(i < 9) ? i + 1 : i], r_bits[(i < 9) ? i + 1 : i]);
            if (!((i < 9) && r_chain[i])) step();
        end

        // Single-cycle unit build: 'E'
        ifb.in_valid = 1'b1; ifb.in_len = 3'd1; ifb.in_bits = 5'b00000;
        chk("b_ready", ifb.in_ready, 1'b1);
        build_exp(3'd1, 5'b00000, 1);
        step();
        ifb.in_valid = 1'b0;
        for (int k = 0; k < exp_q.size(); k++) begin
            chk($sformatf("b_led[%0d]", k), led_b, exp_q[k]);
            chk($sformatf("b_done[%0d]", k), done_b, 1'b0);
            chk($sformatf("b_busy[%0d]", k), busy_b, 1'b1);
            step();
        end
        chk("b_done_pulse", done_b, 1'b1);
        chk("b_ready_at_done", ifb.in_ready, 1'b1);
        step();
        chk("b_done_single", done_b, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
